// File: rtl/dwt53_lifting_core.sv
// dwt53_lifting_core
// Streaming forward LeGall 5/3 reversible DWT using lifting.
// One signed sample is accepted per clock while valid_in is high. One
// (coarse, detail) pair is produced for every two samples. A final flush
// pair is produced on the first idle cycle after a frame. Symmetric
// extension is applied at both frame edges.
// Optional macro DWT_SAT_EN: when defined, the d and s coefficients saturate
// to the DATA_W signed range. When it is not defined, they wrap to DATA_W bits.
module dwt53_lifting_core #(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     valid_in,
  output logic signed [DATA_W-1:0] detail_coefficient,
  output logic signed [DATA_W-1:0] coarse_coefficient,
  output logic                     valid_out
);

  // Internal width: two guard bits cover the sums taken before the shifts.
  localparam int WW = DATA_W + 2;

  // Frame position: idle, last accepted sample even, or last accepted odd.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_EVEN = 2'd1,
    ST_GOT_ODD  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // first_q is high until the first d of the frame exists.
  // It selects the left-edge extension d[-1] = d[0].
  logic first_q, first_d;
  logic valid_out_q, valid_out_d;

  logic signed [DATA_W-1:0] detail_q, detail_d;
  logic signed [DATA_W-1:0] coarse_q, coarse_d;

  // Sample and coefficient history. These registers are not reset;
  // the frame state decides when they are meaningful.
  logic signed [DATA_W-1:0] x_even_q, x_even_d;  // x[2n]
  logic signed [DATA_W-1:0] x_odd_q,  x_odd_d;   // x[2n+1]
  logic signed [DATA_W-1:0] d_prev_q, d_prev_d;  // d[n-1] after fit

  // Sign-extended operands and lifting intermediates.
  logic signed [WW-1:0] x_even_w;
  logic signed [WW-1:0] x_odd_w;
  logic signed [WW-1:0] x_next_w;
  logic signed [WW-1:0] d_prev_w;
  logic signed [WW-1:0] pred_sum;
  logic signed [WW-1:0] d_raw;
  logic signed [DATA_W-1:0] d_fit;
  logic signed [WW-1:0] d_fit_w;
  logic signed [WW-1:0] d_left_w;
  logic signed [WW-1:0] upd_sum;
  logic signed [WW-1:0] s_raw;
  logic signed [WW-1:0] upd_sum_odd;
  logic signed [WW-1:0] s_raw_odd;

  // Reduce a wide intermediate to DATA_W bits, by saturation or by wrap.
  function automatic logic signed [DATA_W-1:0] fit(input logic signed [WW-1:0] v);
`ifdef DWT_SAT_EN
    logic signed [WW-1:0] max_w;
    logic signed [WW-1:0] min_w;
    max_w = {3'b000, {(DATA_W-1){1'b1}}};
    min_w = {3'b111, {(DATA_W-1){1'b0}}};
    if (v > max_w) begin
      fit = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (v < min_w) begin
      fit = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      fit = $signed(v[DATA_W-1:0]);
    end
`else
    fit = $signed(v[DATA_W-1:0]);
`endif
  endfunction

  // Sign-extend a DATA_W value to the internal width.
  function automatic logic signed [WW-1:0] sext(input logic signed [DATA_W-1:0] v);
    sext = {{2{v[DATA_W-1]}}, v};
  endfunction

  // Predict and update datapath, shared by the streaming and flush cases.
  always_comb begin
    x_even_w = sext(x_even_q);
    x_odd_w  = sext(x_odd_q);
    d_prev_w = sext(d_prev_q);
    // At the right edge of an even-length frame x[2N] mirrors to x[2N-2].
    x_next_w = valid_in ? sext(data) : x_even_w;
    pred_sum = x_even_w + x_next_w;
    d_raw    = x_odd_w - (pred_sum >>> 1);
    d_fit    = fit(d_raw);
    d_fit_w  = sext(d_fit);
    d_left_w = first_q ? d_fit_w : d_prev_w;
    upd_sum  = d_left_w + d_fit_w + WW'(2);
    s_raw    = x_even_w + (upd_sum >>> 2);
    // Odd-length tail: the mirrored right neighbour equals d[N-1].
    upd_sum_odd = (d_prev_w <<< 1) + WW'(2);
    s_raw_odd   = x_even_w + (upd_sum_odd >>> 2);
  end

  // Frame sequencing and selection of the output pair.
  always_comb begin
    state_d     = state_q;
    first_d     = first_q;
    valid_out_d = 1'b0;
    detail_d    = detail_q;
    coarse_d    = coarse_q;
    x_even_d    = x_even_q;
    x_odd_d     = x_odd_q;
    d_prev_d    = d_prev_q;
    case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          x_even_d = data;
          first_d  = 1'b1;
          state_d  = ST_GOT_EVEN;
        end
      end
      ST_GOT_EVEN: begin
        if (valid_in) begin
          x_odd_d = data;
          state_d = ST_GOT_ODD;
        end else begin
          // Odd-length frame ends with a single even sample. Its detail is 0.
          detail_d    = '0;
          coarse_d    = first_q ? x_even_q : fit(s_raw_odd);
          valid_out_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_GOT_ODD: begin
        detail_d    = d_fit;
        coarse_d    = fit(s_raw);
        valid_out_d = 1'b1;
        d_prev_d    = d_fit;
        first_d     = 1'b0;
        if (valid_in) begin
          x_even_d = data;
          state_d  = ST_GOT_EVEN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers. The reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      first_q     <= 1'b1;
      valid_out_q <= 1'b0;
      detail_q    <= '0;
      coarse_q    <= '0;
    end else begin
      state_q     <= state_d;
      first_q     <= first_d;
      valid_out_q <= valid_out_d;
      detail_q    <= detail_d;
      coarse_q    <= coarse_d;
    end
  end

  // History registers. The frame state governs when these are valid.
  always_ff @(posedge clk) begin
    x_even_q <= x_even_d;
    x_odd_q  <= x_odd_d;
    d_prev_q <= d_prev_d;
  end

  assign detail_coefficient = detail_q;
  assign coarse_coefficient = coarse_q;
  assign valid_out          = valid_out_q;

endmodule

// File: tb/tb_dwt53_lifting_core.sv
// Directed testbench for dwt53_lifting_core with DATA_W = 16.
// The expected pairs are worked out by hand from the 5/3 lifting equations.
module tb_dwt53_lifting_core;

  logic               clk;
  logic               rst;
  logic signed [15:0] data;
  logic               valid_in;
  logic signed [15:0] detail_coefficient;
  logic signed [15:0] coarse_coefficient;
  logic               valid_out;

  int total;
  int bad;

  dwt53_lifting_core #(.DATA_W(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .data               (data),
    .valid_in           (valid_in),
    .detail_coefficient (detail_coefficient),
    .coarse_coefficient (coarse_coefficient),
    .valid_out          (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply the inputs for one clock, then settle 1 time unit past the edge.
  task automatic step(input logic r, input logic v, input logic signed [15:0] d);
    rst      = r;
    valid_in = v;
    data     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_v(input string tag, input logic ev);
    total++;
    assert (valid_out === ev) else begin
      bad++;
      $error("FAIL %s valid_out got=%0b want=%0b", tag, valid_out, ev);
    end
  endtask

  task automatic chk_pair(input string tag, input logic signed [15:0] es,
                          input logic signed [15:0] ed);
    total++;
    assert (coarse_coefficient === es) else begin
      bad++;
      $error("FAIL %s coarse got=%0d want=%0d", tag, coarse_coefficient, es);
    end
    total++;
    assert (detail_coefficient === ed) else begin
      bad++;
      $error("FAIL %s detail got=%0d want=%0d", tag, detail_coefficient, ed);
    end
  endtask

  // Accept one sample and check whether a pulse is expected.
  task automatic smp(input string tag, input logic signed [15:0] d, input logic ev);
    step(1'b0, 1'b1, d);
    chk_v(tag, ev);
  endtask

  task automatic idle(input string tag, input logic ev);
    step(1'b0, 1'b0, 16'sd0);
    chk_v(tag, ev);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    data     = '0;

    // Reset state.
    step(1'b1, 1'b0, 16'sd0);
    step(1'b1, 1'b1, 16'sd77);
    chk_v("reset", 1'b0);
    chk_pair("reset", 16'sd0, 16'sd0);

    // 1. Even-length ramp.
    smp("t1_x0", 16'sd1, 1'b0);
    smp("t1_x1", 16'sd5, 1'b0);
    smp("t1_x2", 16'sd6, 1'b1);
    chk_pair("t1_p0", 16'sd2, 16'sd2);
    smp("t1_x3", 16'sd9, 1'b0);
    chk_pair("t1_hold", 16'sd2, 16'sd2);
    smp("t1_x4", 16'sd12, 1'b1);
    chk_pair("t1_p1", 16'sd7, 16'sd0);
    smp("t1_x5", 16'sd16, 1'b0);
    smp("t1_x6", 16'sd18, 1'b1);
    chk_pair("t1_p2", 16'sd12, 16'sd1);
    smp("t1_x7", 16'sd22, 1'b0);
    idle("t1_flush", 1'b1);
    chk_pair("t1_p3", 16'sd19, 16'sd4);
    idle("t1_idle", 1'b0);
    chk_pair("t1_idle_hold", 16'sd19, 16'sd4);

    // 2. Odd-length frame.
    smp("t2_x0", 16'sd4, 1'b0);
    smp("t2_x1", 16'sd8, 1'b0);
    smp("t2_x2", 16'sd2, 1'b1);
    chk_pair("t2_p0", 16'sd7, 16'sd5);
    idle("t2_flush", 1'b1);
    chk_pair("t2_p1", 16'sd5, 16'sd0);
    idle("t2_idle", 1'b0);

    // 3. Single sample.
    smp("t3_x0", 16'shAAAA, 1'b0);
    idle("t3_flush", 1'b1);
    chk_pair("t3_p0", 16'shAAAA, 16'sd0);
    idle("t3_idle", 1'b0);

    // 4. Overflow in the predict step.
    smp("t4_x0", 16'sd32767, 1'b0);
    smp("t4_x1", -16'sd32768, 1'b0);
    smp("t4_x2", 16'sd32767, 1'b1);
`ifdef DWT_SAT_EN
    chk_pair("t4_p0", 16'sd16383, -16'sd32768);
`else
    chk_pair("t4_p0", -16'sd32768, 16'sd1);
`endif
    idle("t4_flush", 1'b1);
`ifdef DWT_SAT_EN
    chk_pair("t4_p1", 16'sd16383, 16'sd0);
`else
    chk_pair("t4_p1", -16'sd32768, 16'sd0);
`endif
    idle("t4_idle", 1'b0);

    // Negative samples check that floor rounds toward minus infinity.
    smp("neg_x0", -16'sd3, 1'b0);
    smp("neg_x1", -16'sd4, 1'b0);
    smp("neg_x2", -16'sd6, 1'b1);
    chk_pair("neg_p0", -16'sd2, 16'sd1);
    idle("neg_flush", 1'b1);
    chk_pair("neg_p1", -16'sd5, 16'sd0);
    idle("neg_idle", 1'b0);

    // 5. Reset in the middle of a frame.
    smp("t5_a0", 16'sd7, 1'b0);
    smp("t5_a1", 16'sd3, 1'b0);
    smp("t5_a2", 16'sd11, 1'b1);
    chk_pair("t5_ap0", 16'sd4, -16'sd6);
    step(1'b1, 1'b1, 16'sd99);
    chk_v("t5_rst", 1'b0);
    chk_pair("t5_rst", 16'sd0, 16'sd0);
    smp("t5_x0", 16'sd1, 1'b0);
    chk_pair("t5_x0_hold", 16'sd0, 16'sd0);
    smp("t5_x1", 16'sd5, 1'b0);
    smp("t5_x2", 16'sd6, 1'b1);
    chk_pair("t5_p0", 16'sd2, 16'sd2);
    smp("t5_x3", 16'sd9, 1'b0);
    idle("t5_flush", 1'b1);
    chk_pair("t5_p1", 16'sd7, 16'sd3);

    // 6. Back-to-back frames separated by one idle cycle.
    smp("t6_a0", 16'sd1, 1'b0);
    smp("t6_a1", 16'sd5, 1'b0);
    smp("t6_a2", 16'sd6, 1'b1);
    chk_pair("t6_ap0", 16'sd2, 16'sd2);
    smp("t6_a3", 16'sd9, 1'b0);
    idle("t6_gap", 1'b1);
    chk_pair("t6_ap1", 16'sd7, 16'sd3);
    smp("t6_b0", 16'sd10, 1'b0);
    smp("t6_b1", 16'sd20, 1'b0);
    smp("t6_b2", 16'sd30, 1'b1);
    chk_pair("t6_bp0", 16'sd10, 16'sd0);
    smp("t6_b3", 16'sd40, 1'b0);
    idle("t6_flush", 1'b1);
    chk_pair("t6_bp1", 16'sd33, 16'sd10);
    idle("t6_idle", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
